reg_bank_arbiter: RTL
=====================

# reg_bank_arbiter

Round-robin write arbiter sharing a small bank of 8-bit registers among several requesters. Each requester asks for a write with a data byte and a register index. The block grants one requester at a time, captures its data, and commits it into the selected register. The block sits between the control units and the shared register storage, and it is the only writer to that storage.

## Interface
- N_REQ, 4, number of requesters (2..8)
- N_REGS, 4, number of 8-bit registers in the bank (power of two, 2..16)
- AW, $clog2(N_REGS), register index width (derived, do not override)

- clock  in  1  single clock; all state changes on rising edge
- resetp  in  1  reset, asynchronous, active-high; clears all state immediately
- req  in  N_REQ  per-requester write request, level
- addr  in  N_REQ*AW  flattened register indices; requester i at [i*AW +: AW]
- d  in  N_REQ*8  flattened write data; requester i at [i*8 +: 8]
- gnt  out  N_REQ  one-hot grant, registered
- done  out  1  one-cycle pulse, write committed
- done_id  out  $clog2(N_REQ)  index of requester whose write completed; valid while done=1
- q  out  N_REGS*8  flattened bank contents; register r at [r*8 +: 8]

## Operation
- FSM states: IDLE, GRANT, COMMIT (encodings 2'b00, 2'b01, 2'b10).
- IDLE, req != 0:
  - rr_pick selects the first requester with req set, searching upward from ptr with wrap.
  - gnt <= onehot(winner); win <= winner; state -> GRANT.
- IDLE, req == 0: stay; gnt = 0.
- GRANT, req[win] = 1:
  - hold_addr <= addr[win]; hold_d <= d[win]; gnt <= 0; state -> COMMIT.
- GRANT, req[win] = 0 (abort):
  - gnt <= 0; state -> IDLE; no write; ptr unchanged; done stays 0.
- COMMIT:
  - bank[hold_addr] <= hold_d; done <= 1; done_id <= win; ptr <= (win+1) mod N_REQ; state -> IDLE.
- Only the winning requester's addr/d are sampled. Other requesters' inputs are ignored.
- Requester protocol:
  - Hold req, addr and d stable from assertion through the cycle gnt is high.
  - Drop req in the cycle after seeing gnt, unless another write is wanted.
- A req still high in IDLE after its own commit counts as a new request. Round-robin fairness applies, so the requester goes last among the active requesters.
- addr beyond N_REGS-1 cannot occur (AW exact). The write touches only the indexed register.

## Timing
- Reset (resetp=1, any time, asynchronous):
  - state=IDLE, gnt=0, done=0, done_id=0, ptr=0, all bank registers=8'h00, q=0.
  - An in-flight transaction is discarded with no partial write.
- Edge numbering for one transaction:
  - Edge E0: IDLE sees req. gnt is high in cycle E0..E1.
  - Edge E1: data captured.
  - Edge E2: bank written. q shows the new value and done=1 in cycle E2..E3.
- Request-to-q latency is 3 edges. Peak throughput is 1 write per 3 cycles.
- Earliest next grant is edge E3, in the same cycle that done is visible.
- gnt is never high for more than 1 cycle per transaction. At most one gnt bit is set.
- Simultaneous requests resolve by ptr only. There is no fixed priority after reset except ptr=0 (requester 0 first).
- Reset deasserted mid-cycle: first possible grant is the first rising edge with resetp=0.

## Structure
- Package reg_bank_arbiter_pkg:
  - state encodings IDLE/GRANT/COMMIT
  - default N_REQ/N_REGS constants
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: winner index and any_req.
- Storage: N_REGS instances of the team's eight_bit_register.
  - enable = (state==COMMIT && hold_addr==r).
  - Register reset is tied to resetp.
- Top level contains the FSM, ptr, win, hold_addr, hold_d, done and done_id registers.

## Test plan
- Reset: pulse resetp mid-cycle with the bank preloaded.
  - Expect q=0, gnt=0 and done=0 immediately, before any clock edge.
- Single write: req=4'b0100, addr[2]=2'd3, d[2]=8'hA5.
  - Expect gnt=4'b0100 after E0, q[31:24]=8'hA5 and done=1 with done_id=2 after E2, and the other registers unchanged.
- Round-robin fairness: req=4'b1111 held, each requester writing a distinct byte.
  - Expect grant order 0,1,2,3,0.
  - Expect done every 3 cycles and done_id following the same order.
- Abort: requester 1 drops req in its GRANT cycle.
  - Expect no write, done=0, and the next grant still starting the search at the old ptr.
- Reset mid-transaction: assert resetp while in COMMIT with hold_d=8'h3C.
  - Expect the bank to stay all zero, no done, and the FSM back in IDLE.
- Same-register collision: requester 0 then requester 3 both target register 1, with 8'h11 then 8'h22.
  - Expect final q[15:8]=8'h22, and done pulses 3 cycles apart.

Source files
------------

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and default sizing for the round-robin register-bank write arbiter.
package reg_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT  = 2'b01,
        COMMIT = 2'b10
    } state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_N_REGS = 4;

endpackage

// File: rtl/eight_bit_register.sv
// Byte-wide storage register with load enable and asynchronous active-high clear.
module eight_bit_register (
    input  logic       clock,
    input  logic       resetp,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            q <= 8'h00;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester with req set, searching upward from ptr with wrap.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             any_req
);

    always_comb begin
        winner  = '0;
        any_req = |req;
        // Scan farthest-first so the closest active requester to ptr is the last assignment.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[IW'((int'(ptr) + k) % N_REQ)]) begin
                winner = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter: grants one requester, captures its byte, commits it into the shared bank.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter  int N_REQ  = DEF_N_REQ,
    parameter  int N_REGS = DEF_N_REGS,
    localparam int AW     = $clog2(N_REGS),
    localparam int IW     = $clog2(N_REQ)
) (
    input  logic                clock,
    input  logic                resetp,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*8-1:0]  d,
    output logic [N_REQ-1:0]    gnt,
    output logic                done,
    output logic [IW-1:0]       done_id,
    output logic [N_REGS*8-1:0] q
);

    // state  | meaning
    // IDLE   | waiting for any request; picks a winner and raises its grant
    // GRANT  | grant visible; captures winner's addr/d, or aborts if it dropped req
    // COMMIT | writes the held byte into the bank, pulses done, advances ptr

    state_t            state, state_n;
    logic [N_REQ-1:0]  gnt_n;
    logic [IW-1:0]     win, win_n;
    logic [IW-1:0]     ptr, ptr_n;
    logic [IW-1:0]     done_id_n;
    logic [AW-1:0]     hold_addr, hold_addr_n;
    logic [7:0]        hold_d, hold_d_n;
    logic              done_n;
    logic [IW-1:0]     pick_win;
    logic              any_req;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (pick_win),
        .any_req (any_req)
    );

    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            state     <= IDLE;
            gnt       <= '0;
            win       <= '0;
            ptr       <= '0;
            hold_addr <= '0;
            hold_d    <= 8'h00;
            done      <= 1'b0;
            done_id   <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            win       <= win_n;
            ptr       <= ptr_n;
            hold_addr <= hold_addr_n;
            hold_d    <= hold_d_n;
            done      <= done_n;
            done_id   <= done_id_n;
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = '0;
        win_n       = win;
        ptr_n       = ptr;
        hold_addr_n = hold_addr;
        hold_d_n    = hold_d;
        done_n      = 1'b0;
        done_id_n   = done_id;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_n[pick_win] = 1'b1;
                    win_n           = pick_win;
                    state_n         = GRANT;
                end
            end
            GRANT: begin
                // A requester that let go of req during its grant forfeits without moving ptr.
                if (req[win]) begin
                    hold_addr_n = addr[int'(win)*AW +: AW];
                    hold_d_n    = d[int'(win)*8 +: 8];
                    state_n     = COMMIT;
                end else begin
                    state_n = IDLE;
                end
            end
            COMMIT: begin
                done_n    = 1'b1;
                done_id_n = win;
                ptr_n     = IW'((int'(win) + 1) % N_REQ);
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    for (genvar r = 0; r < N_REGS; r++) begin : g_bank
        eight_bit_register u_reg (
            .clock  (clock),
            .resetp (resetp),
            .en     (state == COMMIT && hold_addr == AW'(r)),
            .d      (hold_d),
            .q      (q[r*8 +: 8])
        );
    end

endmodule
